// File: rtl/obi_mem_responder_if.sv
// Address-phase and response-phase signals of an OBI-style memory port.
// master = requesting core side, slave = memory responder side.
interface obi_mem_responder_if #(
  parameter int STALL_WIDTH = 4
) ();
  logic                   req_i;
  logic                   gnt_o;
  logic [31:0]            addr_i;
  logic                   we_i;
  logic [3:0]             be_i;
  logic [31:0]            wdata_i;
  logic                   rvalid_o;
  logic [31:0]            rdata_o;
  logic [STALL_WIDTH-1:0] gnt_stall_i;
  logic [STALL_WIDTH-1:0] rvalid_stall_i;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, gnt_stall_i, rvalid_stall_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, gnt_stall_i, rvalid_stall_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/obi_mem_responder.sv
// OBI memory responder: word RAM with byte enables, programmable grant stall and
// per-transaction response stall, in-order responses from a small outstanding FIFO.
module obi_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int OUTSTANDING    = 2,
  parameter int STALL_WIDTH    = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  obi_mem_responder_if.slave bus
);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(OUTSTANDING - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                   r_state, w_state_next;
  logic [STALL_WIDTH-1:0]   r_gcnt, w_gcnt_next;
  logic                     w_full, w_gnt, w_accept, w_pop;

  logic [31:0]              r_mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic [31:0]              r_ram_q;
  logic                     r_fill_vld;
  logic [PTR_W-1:0]         r_fill_slot;

  logic [31:0]              w_slot_data  [OUTSTANDING];
  logic [STALL_WIDTH-1:0]   w_stall_next [OUTSTANDING];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr, w_wr_ptr_next, w_rd_ptr_next;
  logic [CNT_W-1:0]         r_count, w_count_next;
  logic                     r_rvalid, w_rvalid_next;
  logic [31:0]              r_rdata_last, w_head_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gcnt  <= w_gcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gcnt_next  = r_gcnt;
    w_gnt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          if (bus.gnt_stall_i != '0) begin
            w_state_next = S_WAIT;
            w_gcnt_next  = bus.gnt_stall_i - STALL_WIDTH'(1);
          end else if (w_full) begin
            w_state_next = S_WAIT;
            w_gcnt_next  = '0;
          end else begin
            w_gnt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!bus.req_i) begin
          w_state_next = S_IDLE;
          w_gcnt_next  = '0;
        end else if (r_gcnt != '0) begin
          w_gcnt_next = r_gcnt - STALL_WIDTH'(1);
        end else if (!w_full) begin
          w_gnt        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (rst_i) w_gnt = 1'b0;
  end

  assign w_full   = (r_count == CNT_W'(OUTSTANDING));
  assign w_accept = bus.req_i && w_gnt;
  assign w_pop    = r_rvalid;
  assign w_idx    = bus.addr_i[MEM_ADDR_WIDTH+1:2];

  // Read data lands in r_ram_q one cycle after grant and is copied into its slot then.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      if (bus.we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.be_i[k]) r_mem[w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
        end
      end else begin
        r_ram_q <= r_mem[w_idx];
      end
    end
  end

  // Every slot's stall counts down each cycle, so queued entries age in parallel.
  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_slot
    logic [31:0]            r_data_q;
    logic [STALL_WIDTH-1:0] r_stall_q;
    logic                   w_push_here;

    assign w_push_here     = w_accept && (r_wr_ptr == PTR_W'(gi));
    assign w_stall_next[gi] = w_push_here          ? bus.rvalid_stall_i :
                              (r_stall_q != '0)    ? r_stall_q - STALL_WIDTH'(1) : '0;
    assign w_slot_data[gi] = r_data_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) r_stall_q <= '0;
      else       r_stall_q <= w_stall_next[gi];
    end

    always_ff @(posedge clk_i) begin
      if (w_push_here && bus.we_i)                          r_data_q <= '0;
      else if (r_fill_vld && (r_fill_slot == PTR_W'(gi)))   r_data_q <= r_ram_q;
    end
  end

  assign w_wr_ptr_next = w_accept ? ptr_inc(r_wr_ptr) : r_wr_ptr;
  assign w_rd_ptr_next = w_pop    ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  assign w_count_next  = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
  assign w_rvalid_next = (w_count_next != '0) && (w_stall_next[w_rd_ptr_next] == '0);
  assign w_head_data   = (r_fill_vld && (r_fill_slot == r_rd_ptr)) ? r_ram_q
                                                                   : w_slot_data[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rvalid     <= 1'b0;
      r_rdata_last <= '0;
      r_fill_vld   <= 1'b0;
      r_fill_slot  <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_rvalid    <= w_rvalid_next;
      r_fill_vld  <= w_accept && !bus.we_i;
      r_fill_slot <= r_wr_ptr;
      if (r_rvalid) r_rdata_last <= w_head_data;
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rvalid ? w_head_data : r_rdata_last;

  // A requester must keep req_i high until it is granted.
  ap_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
                                (r_state == S_WAIT) |-> bus.req_i);
endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed scoreboard bench for obi_mem_responder: the driver pushes expected
// responses (data and arrival cycle) at grant; a monitor pops and compares on rvalid.
module tb_obi_mem_responder;
  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   rv_seen;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  obi_mem_responder_if #(.STALL_WIDTH(4)) bus ();

  obi_mem_responder #(
    .MEM_ADDR_WIDTH(10),
    .OUTSTANDING   (2),
    .STALL_WIDTH   (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bus.rvalid_o === 1'b1) begin
      rv_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: got rvalid at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("rsp%0d_data", mon_e.id), bus.rdata_o, mon_e.data);
        check($sformatf("rsp%0d_cycle", mon_e.id), 32'(cyc), 32'(mon_e.cyc));
        $display("rsp id=%0d cycle=%0d rdata=0x%08h", mon_e.id, cyc, bus.rdata_o);
      end
    end
  end

  // Caller is at posedge+#1 of the request cycle; returns at posedge+#1 after the grant cycle.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input int gst, input int rst_stall,
                       input int exp_gnt_off, input int exp_rsp_off,
                       input logic [31:0] exp_data, input int id);
    int   start;
    int   waited;
    logic granted;
    bus.req_i          = 1'b1;
    bus.addr_i         = addr;
    bus.we_i           = we;
    bus.be_i           = be;
    bus.wdata_i        = wdata;
    bus.gnt_stall_i    = 4'(gst);
    bus.rvalid_stall_i = 4'(rst_stall);
    start   = cyc;
    waited  = 0;
    granted = 1'b0;
    while (!granted && waited < 40) begin
      @(negedge clk);
      if (bus.gnt_o === 1'b1) begin
        granted = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    if (granted) begin
      check($sformatf("req%0d_gnt_delay", id), 32'(cyc - start), 32'(exp_gnt_off));
      sb.push_back('{data: exp_data, cyc: start + exp_rsp_off, id: id});
      $display("req id=%0d %s addr=0x%08h start=%0d grant=%0d", id, we ? "WR" : "RD",
               addr, start, cyc);
    end else begin
      total++;
      bad++;
      $display("FAIL req%0d_grant_timeout: got no grant in 40 cycles, required one", id);
    end
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d responses still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int rv_before;
    bus.req_i          = 1'b0;
    bus.addr_i         = '0;
    bus.we_i           = 1'b0;
    bus.be_i           = '0;
    bus.wdata_i        = '0;
    bus.gnt_stall_i    = '0;
    bus.rvalid_stall_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_gnt", 32'(bus.gnt_o), 32'd0);
    check("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("reset_rdata", bus.rdata_o, 32'd0);
    @(posedge clk);
    #1;

    // Stall-0 write then read of the same word
    issue(32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0, 1);
    issue(32'h100, 1'b0, 4'hF, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 2);
    drain();

    // Partial byte-enable write over an all-ones word
    issue(32'h200, 1'b1, 4'hF,    32'hFFFFFFFF, 0, 0, 0, 1, 32'h0, 3);
    issue(32'h200, 1'b1, 4'b0101, 32'h11223344, 0, 0, 0, 1, 32'h0, 4);
    issue(32'h200, 1'b0, 4'hF,    32'h0,        0, 0, 0, 1, 32'hFF22FF44, 5);
    drain();

    // Grant stall 3, response stall 2
    issue(32'h200, 1'b0, 4'hF, 32'h0, 3, 2, 3, 6, 32'hFF22FF44, 6);
    drain();

    // FIFO full: third read waits for the first response to leave
    issue(32'h100, 1'b0, 4'hF, 32'h0, 0, 5, 0, 6,  32'hDEADBEEF, 7);
    issue(32'h200, 1'b0, 4'hF, 32'h0, 0, 5, 0, 6,  32'hFF22FF44, 8);
    issue(32'h100, 1'b0, 4'hF, 32'h0, 0, 5, 5, 11, 32'hDEADBEEF, 9);
    drain();

    // Address aliasing above the RAM size
    issue(32'h1000, 1'b1, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 1, 32'h0, 10);
    issue(32'h0000, 1'b0, 4'hF, 32'h0,        0, 0, 0, 1, 32'hA5A5A5A5, 11);
    drain();

    // Reset with two reads outstanding
    issue(32'h100, 1'b0, 4'hF, 32'h0, 0, 8, 0, 9, 32'hDEADBEEF, 12);
    issue(32'h200, 1'b0, 4'hF, 32'h0, 0, 8, 0, 9, 32'hFF22FF44, 13);
    @(posedge clk);
    #1;
    rv_before = rv_seen;
    sb.delete();
    rst             = 1'b1;
    bus.req_i       = 1'b1;
    bus.gnt_stall_i = '0;
    @(negedge clk);
    check("gnt_in_reset", 32'(bus.gnt_o), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clk);
    check("post_reset_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("post_reset_rdata", bus.rdata_o, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("rvalid_after_reset_count", 32'(rv_seen - rv_before), 32'd0);
    issue(32'h100, 1'b0, 4'hF, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF, 14);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000ns, required finish");
    $fatal(1, "watchdog");
  end
endmodule
